// File: rtl/regfile_write_arbiter.sv
// Three-source register-file write-back arbiter with per-register ordering and hazard query.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed priority MEM > LINK > ALU.
module regfile_write_arbiter #(
   parameter logic [5:0] LINK_REG = 6'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        alu_valid,
   input  logic [5:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [5:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        link_valid,
   input  logic [31:0] link_data,
   output logic        link_ready,
   input  logic [5:0]  rs_addr,
   input  logic [5:0]  rt_addr,
   output logic        rs_pending,
   output logic        rt_pending,
   output logic        wr_en,
   output logic [5:0]  wr_addr,
   output logic [31:0] wr_data
);

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_MEM  = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;

   logic        r_alu_v;
   logic [5:0]  r_alu_rd;
   logic [31:0] r_alu_data;
   logic        r_mem_v;
   logic [5:0]  r_mem_rd;
   logic [31:0] r_mem_data;
   logic        r_link_v;
   logic [31:0] r_link_data;
   logic        r_wr_en;
   logic [5:0]  r_wr_addr;
   logic [31:0] r_wr_data;
`ifdef RR_ARB_EN
   logic [1:0]  r_ptr;
`endif

   logic [2:0]  w_gnt;
   logic [1:0]  w_gnt_src;
   logic [5:0]  w_gnt_rd;
   logic [31:0] w_gnt_data;
   logic        w_alu_hit;
   logic        w_mem_hit;
   logic        w_link_hit;
   logic        w_alu_acc;
   logic        w_mem_acc;
   logic        w_link_acc;

   // Grant selection: w_gnt bit 0 = ALU, bit 1 = MEM, bit 2 = LINK.
   always_comb begin
      w_gnt = 3'b000;
`ifdef RR_ARB_EN
      case (r_ptr)
         SRC_ALU: begin
            if (r_mem_v)       w_gnt = 3'b010;
            else if (r_link_v) w_gnt = 3'b100;
            else if (r_alu_v)  w_gnt = 3'b001;
            else               w_gnt = 3'b000;
         end
         SRC_MEM: begin
            if (r_link_v)      w_gnt = 3'b100;
            else if (r_alu_v)  w_gnt = 3'b001;
            else if (r_mem_v)  w_gnt = 3'b010;
            else               w_gnt = 3'b000;
         end
         SRC_LINK: begin
            if (r_alu_v)       w_gnt = 3'b001;
            else if (r_mem_v)  w_gnt = 3'b010;
            else if (r_link_v) w_gnt = 3'b100;
            else               w_gnt = 3'b000;
         end
         default: begin
            if (r_mem_v)       w_gnt = 3'b010;
            else if (r_link_v) w_gnt = 3'b100;
            else if (r_alu_v)  w_gnt = 3'b001;
            else               w_gnt = 3'b000;
         end
      endcase
`else
      if (r_mem_v)       w_gnt = 3'b010;
      else if (r_link_v) w_gnt = 3'b100;
      else if (r_alu_v)  w_gnt = 3'b001;
      else               w_gnt = 3'b000;
`endif
   end

   // Granted entry mux.
   always_comb begin
      w_gnt_src  = SRC_ALU;
      w_gnt_rd   = 6'd0;
      w_gnt_data = 32'd0;
      case (w_gnt)
         3'b001: begin
            w_gnt_src  = SRC_ALU;
            w_gnt_rd   = r_alu_rd;
            w_gnt_data = r_alu_data;
         end
         3'b010: begin
            w_gnt_src  = SRC_MEM;
            w_gnt_rd   = r_mem_rd;
            w_gnt_data = r_mem_data;
         end
         3'b100: begin
            w_gnt_src  = SRC_LINK;
            w_gnt_rd   = LINK_REG;
            w_gnt_data = r_link_data;
         end
         default: begin
            w_gnt_src  = SRC_ALU;
            w_gnt_rd   = 6'd0;
            w_gnt_data = 32'd0;
         end
      endcase
   end

   // Same-edge arrivals to one register are also serialised (MEM, then LINK, then ALU),
   // so no two buffers can ever hold the same destination.
   assign w_alu_hit  = (r_mem_v && (r_mem_rd == alu_rd)) || (r_link_v && (LINK_REG == alu_rd)) ||
                       (mem_valid && (mem_rd == alu_rd)) || (link_valid && (LINK_REG == alu_rd));
   assign w_mem_hit  = (r_alu_v && (r_alu_rd == mem_rd)) || (r_link_v && (LINK_REG == mem_rd));
   assign w_link_hit = (r_alu_v && (r_alu_rd == LINK_REG)) || (r_mem_v && (r_mem_rd == LINK_REG)) ||
                       (mem_valid && (mem_rd == LINK_REG));

   assign alu_ready  = !reset && (!r_alu_v  || w_gnt[0]) && !w_alu_hit;
   assign mem_ready  = !reset && (!r_mem_v  || w_gnt[1]) && !w_mem_hit;
   assign link_ready = !reset && (!r_link_v || w_gnt[2]) && !w_link_hit;

   assign w_alu_acc  = alu_valid  && alu_ready;
   assign w_mem_acc  = mem_valid  && mem_ready;
   assign w_link_acc = link_valid && link_ready;

   assign rs_pending = (rs_addr != 6'd0) &&
                       ((r_alu_v && (r_alu_rd == rs_addr)) || (r_mem_v && (r_mem_rd == rs_addr)) ||
                        (r_link_v && (LINK_REG == rs_addr)) || (r_wr_en && (r_wr_addr == rs_addr)));
   assign rt_pending = (rt_addr != 6'd0) &&
                       ((r_alu_v && (r_alu_rd == rt_addr)) || (r_mem_v && (r_mem_rd == rt_addr)) ||
                        (r_link_v && (LINK_REG == rt_addr)) || (r_wr_en && (r_wr_addr == rt_addr)));

   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;

   // Buffer fill/free, write-port register and arbitration pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_alu_v     <= 1'b0;
         r_alu_rd    <= 6'd0;
         r_alu_data  <= 32'd0;
         r_mem_v     <= 1'b0;
         r_mem_rd    <= 6'd0;
         r_mem_data  <= 32'd0;
         r_link_v    <= 1'b0;
         r_link_data <= 32'd0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= 6'd0;
         r_wr_data   <= 32'd0;
`ifdef RR_ARB_EN
         r_ptr       <= SRC_ALU;
`endif
      end else begin
         if (w_alu_acc) begin
            r_alu_v    <= 1'b1;
            r_alu_rd   <= alu_rd;
            r_alu_data <= alu_data;
         end else if (w_gnt[0]) begin
            r_alu_v    <= 1'b0;
         end
         if (w_mem_acc) begin
            r_mem_v    <= 1'b1;
            r_mem_rd   <= mem_rd;
            r_mem_data <= mem_data;
         end else if (w_gnt[1]) begin
            r_mem_v    <= 1'b0;
         end
         if (w_link_acc) begin
            r_link_v    <= 1'b1;
            r_link_data <= link_data;
         end else if (w_gnt[2]) begin
            r_link_v    <= 1'b0;
         end
         // A grant to register 0 frees its buffer but produces no bank write.
         if ((w_gnt != 3'b000) && (w_gnt_rd != 6'd0)) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_gnt_rd;
            r_wr_data <= w_gnt_data;
         end else begin
            r_wr_en   <= 1'b0;
         end
`ifdef RR_ARB_EN
         if (w_gnt != 3'b000) begin
            r_ptr <= w_gnt_src;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes queued at issue, checked by a monitor.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        alu_valid = 1'b0;
   logic [5:0]  alu_rd = 6'd0;
   logic [31:0] alu_data = 32'd0;
   logic        alu_ready;
   logic        mem_valid = 1'b0;
   logic [5:0]  mem_rd = 6'd0;
   logic [31:0] mem_data = 32'd0;
   logic        mem_ready;
   logic        link_valid = 1'b0;
   logic [31:0] link_data = 32'd0;
   logic        link_ready;
   logic [5:0]  rs_addr = 6'd0;
   logic [5:0]  rt_addr = 6'd0;
   logic        rs_pending;
   logic        rt_pending;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   regfile_write_arbiter dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .link_valid(link_valid), .link_data(link_data), .link_ready(link_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   bit  stress_on = 1'b0;
   int  stress_idx = 0;
   int  cnt_alu = 0;
   int  cnt_mem = 0;
   int  cnt_link = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every bank write must match the head of the expected queue.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_wr_addr", {26'd0, wr_addr}, {26'd0, mon_e.a});
            chk("sb_wr_data", wr_data, mon_e.d);
         end
         if (stress_on) begin
            if (stress_idx < 30) begin
               if (wr_addr == 6'd10) cnt_alu++;
               else if (wr_addr == 6'd11) cnt_mem++;
               else if (wr_addr == 6'd1) cnt_link++;
            end
            stress_idx++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with requests presented during reset.
      alu_valid = 1'b1; alu_rd = 6'd2; mem_valid = 1'b1; mem_rd = 6'd3; link_valid = 1'b1;
      rs_addr = 6'd2;
      @(negedge clock);
      @(negedge clock);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_link_ready", {31'd0, link_ready}, 32'd0);
      chk("rst_rs_pending", {31'd0, rs_pending}, 32'd0);
      alu_valid = 1'b0; mem_valid = 1'b0; link_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);

      // Single ALU write, latency and hazard window.
      alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 32'hA5; rs_addr = 6'd5; rt_addr = 6'd9;
      #1;
      chk("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("t1_rs_pend_pre", {31'd0, rs_pending}, 32'd0);
      push(6'd5, 32'hA5);
      @(negedge clock);
      alu_valid = 1'b0;
      chk("t1_rs_pend_c1", {31'd0, rs_pending}, 32'd1);
      chk("t1_rt_pend_c1", {31'd0, rt_pending}, 32'd0);
      chk("t1_wr_en_c1", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t1_rs_pend_c2", {31'd0, rs_pending}, 32'd1);
      chk("t1_wr_en_c2", {31'd0, wr_en}, 32'd1);
      @(negedge clock);
      chk("t1_rs_pend_c3", {31'd0, rs_pending}, 32'd0);
      chk("t1_wr_en_c3", {31'd0, wr_en}, 32'd0);

      // ALU and MEM on the same edge: MEM writes first, then ALU.
      alu_valid = 1'b1; alu_rd = 6'd3; alu_data = 32'h33;
      mem_valid = 1'b1; mem_rd = 6'd4; mem_data = 32'h44;
      #1;
      chk("t2_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("t2_mem_ready", {31'd0, mem_ready}, 32'd1);
      push(6'd4, 32'h44);
      push(6'd3, 32'h33);
      @(negedge clock);
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t2_wr_en_c1", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t2_wr_en_c2", {31'd0, wr_en}, 32'd1);
      chk("t2_first_addr", {26'd0, wr_addr}, 32'd4);
      @(negedge clock);
      chk("t2_wr_en_c3", {31'd0, wr_en}, 32'd1);
      chk("t2_second_addr", {26'd0, wr_addr}, 32'd3);
      @(negedge clock);
      chk("t2_wr_en_c4", {31'd0, wr_en}, 32'd0);

      // ALU blocked while MEM holds the same register.
      mem_valid = 1'b1; mem_rd = 6'd7; mem_data = 32'h77;
      #1;
      chk("t3_mem_ready", {31'd0, mem_ready}, 32'd1);
      push(6'd7, 32'h77);
      @(negedge clock);
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 32'h70;
      #1;
      chk("t3_alu_blocked", {31'd0, alu_ready}, 32'd0);
      @(negedge clock);
      chk("t3_mem_written", {31'd0, wr_en}, 32'd1);
      chk("t3_alu_unblocked", {31'd0, alu_ready}, 32'd1);
      push(6'd7, 32'h70);
      @(negedge clock);
      alu_valid = 1'b0;
      chk("t3_wr_en_gap", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t3_alu_written", {31'd0, wr_en}, 32'd1);
      @(negedge clock);
      chk("t3_wr_en_idle", {31'd0, wr_en}, 32'd0);

      // Link write to register 1, then a discarded write to register 0.
      link_valid = 1'b1; link_data = 32'h40;
      #1;
      chk("t4_link_ready", {31'd0, link_ready}, 32'd1);
      push(6'd1, 32'h40);
      @(negedge clock);
      link_valid = 1'b0; rs_addr = 6'd1;
      #1;
      chk("t4_rs_pend_link", {31'd0, rs_pending}, 32'd1);
      @(negedge clock);
      chk("t4_link_wr_en", {31'd0, wr_en}, 32'd1);
      chk("t4_link_addr", {26'd0, wr_addr}, 32'd1);
      alu_valid = 1'b1; alu_rd = 6'd0; alu_data = 32'hDEAD; rs_addr = 6'd0;
      #1;
      chk("t4_r0_ready", {31'd0, alu_ready}, 32'd1);
      @(negedge clock);
      alu_valid = 1'b0;
      chk("t4_r0_pending", {31'd0, rs_pending}, 32'd0);
      chk("t4_r0_wr_en_c1", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t4_r0_wr_en_c2", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t4_r0_wr_en_c3", {31'd0, wr_en}, 32'd0);

      // Reset mid-cycle with all three buffers full.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      alu_valid = 1'b1; alu_rd = 6'd12; alu_data = 32'hC1;
      mem_valid = 1'b1; mem_rd = 6'd13; mem_data = 32'hC2;
      link_valid = 1'b1; link_data = 32'hC3;
      #1;
      chk("t5_alu_ready", {31'd0, alu_ready}, 32'd1);
      chk("t5_mem_ready", {31'd0, mem_ready}, 32'd1);
      chk("t5_link_ready", {31'd0, link_ready}, 32'd1);
      push(6'd13, 32'hC2);
      @(negedge clock);
      chk("t5_alu_full", {31'd0, alu_ready}, 32'd0);
      chk("t5_link_full", {31'd0, link_ready}, 32'd0);
      chk("t5_wr_en_c1", {31'd0, wr_en}, 32'd0);
      @(negedge clock);
      chk("t5_wr_en_c2", {31'd0, wr_en}, 32'd1);
      rs_addr = 6'd12;
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("t5_rst_wr_addr", {26'd0, wr_addr}, 32'd0);
      chk("t5_rst_wr_data", wr_data, 32'd0);
      chk("t5_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("t5_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("t5_rst_link_ready", {31'd0, link_ready}, 32'd0);
      chk("t5_rst_pending", {31'd0, rs_pending}, 32'd0);
      @(negedge clock);
      alu_valid = 1'b0; mem_valid = 1'b0; link_valid = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t5_post_rst_wr_en", {31'd0, wr_en}, 32'd0);
      end

      // All sources valid for 30 cycles from a fresh reset.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      alu_valid = 1'b1; alu_rd = 6'd10; alu_data = 32'h0A0A;
      mem_valid = 1'b1; mem_rd = 6'd11; mem_data = 32'h0B0B;
      link_valid = 1'b1; link_data = 32'h0C0C;
`ifdef RR_ARB_EN
      for (int i = 0; i < 32; i++) begin
         if ((i % 3) == 0)      push(6'd11, 32'h0B0B);
         else if ((i % 3) == 1) push(6'd1, 32'h0C0C);
         else                   push(6'd10, 32'h0A0A);
      end
`else
      for (int i = 0; i < 30; i++) begin
         push(6'd11, 32'h0B0B);
      end
      push(6'd1, 32'h0C0C);
      push(6'd10, 32'h0A0A);
`endif
      stress_on = 1'b1;
      repeat (30) @(negedge clock);
      alu_valid = 1'b0; mem_valid = 1'b0; link_valid = 1'b0;
      repeat (8) @(negedge clock);
      stress_on = 1'b0;
      chk("t6_total_writes", stress_idx, 32'd32);
`ifdef RR_ARB_EN
      chk("t6_alu_grants", cnt_alu, 32'd10);
      chk("t6_mem_grants", cnt_mem, 32'd10);
      chk("t6_link_grants", cnt_link, 32'd10);
`else
      chk("t6_alu_grants", cnt_alu, 32'd0);
      chk("t6_mem_grants", cnt_mem, 32'd30);
      chk("t6_link_grants", cnt_link, 32'd0);
`endif

      chk("sb_queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter LINK_REG, default 6'd1: destination register of every link write.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports alu_valid, input, 1; alu_rd, input, 6; alu_data, input, 32: ALU write-back request.
REQ-005 SHALL have port alu_ready, output, 1: ALU request accepted on an edge where alu_valid and alu_ready are both high.
REQ-006 SHALL have ports mem_valid, input, 1; mem_rd, input, 6; mem_data, input, 32: load write-back request.
REQ-007 SHALL have port mem_ready, output, 1: load handshake, same rule as alu_ready.
REQ-008 SHALL have ports link_valid, input, 1; link_data, input, 32: JAL link write to LINK_REG.
REQ-009 SHALL have port link_ready, output, 1: link handshake, same rule as alu_ready.
REQ-010 SHALL have ports rs_addr, input, 6; rt_addr, input, 6: hazard query addresses.
REQ-011 SHALL have ports rs_pending, output, 1; rt_pending, output, 1: queried register has an unretired write.
REQ-012 SHALL have ports wr_en, output, 1; wr_addr, output, 6; wr_data, output, 32: registered write port to the register bank.

Function
REQ-013 SHALL hold one single-entry buffer per source (ALU, MEM, LINK), each with valid, address and data.
REQ-014 SHALL assert <src>_ready only when that source's buffer is empty and the incoming address matches no other occupied buffer.
REQ-015 SHALL therefore never hold two buffered writes to the same register, preserving per-register write order.
REQ-016 SHALL, each cycle, grant at most one occupied buffer; on the next edge, load wr_en=1, wr_addr and wr_data from it and free that buffer.
REQ-017 SHALL set wr_en=0 on any edge where no buffer is occupied; wr_addr and wr_data then hold their previous values.
REQ-018 SHALL give latency 1: a request accepted at edge k, granted immediately, appears on the write port after edge k+1.
REQ-019 SHALL allow a freed buffer to accept a new request on the same edge on which it is freed, provided REQ-014 holds.
REQ-020 SHALL discard writes to register 0: accepted and freed normally, but wr_en stays 0 for that grant.
REQ-021 SHALL drive rs_pending=1 when rs_addr!=0 and matches an occupied buffer address or wr_addr while wr_en=1; rt_pending likewise.
REQ-022 SHALL compute ready and pending combinationally from current state and inputs; outputs on the write port are registered only.

Reset
REQ-023 SHALL, while reset is high, clear all buffers, force wr_en=0, wr_addr=0, wr_data=0 and round-robin pointer=ALU.
REQ-024 SHALL force alu_ready, mem_ready and link_ready to 0 while reset is high; requests in flight are lost.
REQ-025 SHALL resume acceptance on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with RR_ARB_EN defined, arbitrate round-robin in order ALU -> MEM -> LINK, starting after the last granted source.
REQ-027 SHALL, without RR_ARB_EN, use fixed priority MEM > LINK > ALU.

Verification
REQ-028 SHALL check: alu_valid=1, alu_rd=5, alu_data=32'hA5 accepted at edge 1 -> wr_en=1, wr_addr=5, wr_data=32'hA5 after edge 2, rs_pending=1 for rs_addr=5 during cycles 1-2.
REQ-029 SHALL check: ALU (rd=3) and MEM (rd=4) accepted on the same edge -> two consecutive write cycles; with RR_ARB_EN and pointer=ALU, MEM writes first; without RR_ARB_EN, MEM writes first.
REQ-030 SHALL check: MEM buffered with rd=7, alu_valid with alu_rd=7 -> alu_ready=0 until the MEM write is granted, then ALU accepted and written one cycle later.
REQ-031 SHALL check: link_valid=1, link_data=32'h40 -> wr_addr=1, wr_data=32'h40; alu_rd=0 request -> accepted, wr_en stays 0.
REQ-032 SHALL check: reset asserted mid-cycle with all three buffers full -> wr_en=0 and all ready=0 immediately, no writes after reset releases.
REQ-033 SHALL check: all three sources valid every cycle for 30 cycles under RR_ARB_EN -> each source receives 10 grants, no source starved.
